// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the ALU-sharing arbiter state encoding.
package cpu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ADD = 3'b000,
        OR  = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        NOR = 3'b100,
        SLL = 3'b101,
        ROT = 3'b110,
        SUB = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // One-hot select for a 2-way port index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle for the shared-ALU arbiter: two requester ports, response port and ALU side.
interface alu_share_arb_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 3
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req_srca0;
    logic [WIDTH-1:0]  req_srcb0;
    logic [CTRL_W-1:0] req_ctrl0;
    logic [WIDTH-1:0]  req_srca1;
    logic [WIDTH-1:0]  req_srcb1;
    logic [CTRL_W-1:0] req_ctrl1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic [WIDTH-1:0]  alu_srca;
    logic [WIDTH-1:0]  alu_srcb;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    // Requester side (pipeline stages).
    modport master (
        output req_valid, req_srca0, req_srcb0, req_ctrl0, req_srca1, req_srcb1, req_ctrl1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_srca0, req_srcb0, req_ctrl0, req_srca1, req_srcb1, req_ctrl1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero,
        output alu_srca, alu_srcb, alu_ctrl,
        input  alu_result, alu_zero
    );

    // ALU instance side.
    modport alu (
        input  alu_srca, alu_srcb, alu_ctrl,
        output alu_result, alu_zero
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    // Single requester wins outright; on a tie the non-last port wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
        gnt_idx = gnt[1];
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch-target unit (port 1). One op in flight; result held until consumed.
module alu_share_arb
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 3
) (
    input logic            clk,
    input logic            rst_n,
    alu_share_arb_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              own_q, own_d;
    logic              last_q, last_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;

    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              accept_ok;
    logic              accept;
    logic [1:0]        ready;
    logic [WIDTH-1:0]  srca;
    logic [WIDTH-1:0]  srcb;
    logic [CTRL_W-1:0] ctrl;

    rr_arb2 u_rr_arb2 (
        .req     (bus.req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Accept a new op when empty, or when the held result is consumed this cycle.
    always_comb begin
        accept_ok = (state_q == IDLE) | ((state_q == HOLD) & bus.rsp_ready[own_q]);
        ready     = accept_ok ? gnt : 2'b00;
        accept    = |ready;
    end

    // Steer the granted operands to the ALU; keep its inputs at zero otherwise.
    always_comb begin
        srca = '0;
        srcb = '0;
        ctrl = '0;
        if (accept) begin
            if (gnt_idx) begin
                srca = bus.req_srca1;
                srcb = bus.req_srcb1;
                ctrl = bus.req_ctrl1;
            end else begin
                srca = bus.req_srca0;
                srcb = bus.req_srcb0;
                ctrl = bus.req_ctrl0;
            end
        end
    end

    // Next-state: capture on accept, drop to IDLE when the owner consumes without reissue.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        last_d   = last_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (accept) begin
            state_d  = HOLD;
            own_d    = gnt_idx;
            last_d   = gnt_idx;
            result_d = bus.alu_result;
            zero_d   = bus.alu_zero;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                HOLD: if (bus.rsp_ready[own_q]) state_d = IDLE;
            endcase
        end
    end

    // State and result registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            own_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Outputs: response side decoded straight from registers.
    always_comb begin
        bus.req_ready  = ready;
        bus.alu_srca   = srca;
        bus.alu_srcb   = srcb;
        bus.alu_ctrl   = ctrl;
        bus.rsp_valid  = (state_q == HOLD) ? onehot2(own_q) : 2'b00;
        bus.rsp_result = result_q;
        bus.rsp_zero   = zero_q;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vector table, hand-written reset sequence,
// then randomized traffic against a behavioural model of the sharing rules.
module tb_alu_share_arb;
    import cpu_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_share_arb_if #(.WIDTH(W), .CTRL_W(3)) bus ();

    alu_share_arb #(.WIDTH(W), .CTRL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            ADD:     return a + b;
            OR:      return a | b;
            AND:     return a & b;
            XOR:     return a ^ b;
            NOR:     return ~(a | b);
            SLL:     return a << s;
            ROT:     return (s == 0) ? a : ((a << s) | (a >> (W - s)));
            default: return a - b;
        endcase
    endfunction

    // The bench plays the shared ALU.
    always_comb begin
        bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb);
        bus.alu_zero   = (alu_fn(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb) == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [2:0]   op_c[2];
    logic [W-1:0] op_a[2];
    logic [W-1:0] op_b[2];

    task automatic drive(input logic [1:0] rv, input logic [1:0] rr);
        bus.req_valid = rv;
        bus.rsp_ready = rr;
        bus.req_ctrl0 = op_c[0];
        bus.req_srca0 = op_a[0];
        bus.req_srcb0 = op_b[0];
        bus.req_ctrl1 = op_c[1];
        bus.req_srca1 = op_a[1];
        bus.req_srcb1 = op_b[1];
    endtask

    typedef struct {
        logic [1:0]   rv;
        logic [1:0]   rr;
        logic [2:0]   c0;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [2:0]   c1;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [1:0]   ready;
        logic [1:0]   valid;
        logic [W-1:0] result;
        logic         zero;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] rr,
                                input logic [2:0] c0, input logic [W-1:0] a0,
                                input logic [W-1:0] b0, input logic [2:0] c1,
                                input logic [W-1:0] a1, input logic [W-1:0] b1,
                                input logic [1:0] ready, input logic [1:0] valid,
                                input logic [W-1:0] result, input logic zero);
        vec_t v;
        v.rv = rv; v.rr = rr;
        v.c0 = c0; v.a0 = a0; v.b0 = b0;
        v.c1 = c1; v.a1 = a1; v.b1 = b1;
        v.ready = ready; v.valid = valid; v.result = result; v.zero = zero;
        return v;
    endfunction

    // Behavioural model of the sharing rules.
    bit           m_held;
    int           m_own;
    int           m_last;
    logic [W-1:0] m_res;
    bit           m_zero;

    task automatic model_reset();
        m_held = 0; m_own = 0; m_last = 1; m_res = '0; m_zero = 0;
    endtask

    vec_t vecs[13];

    initial begin
        logic [1:0] rv;
        logic [1:0] rr;
        logic [1:0] pend;
        logic [1:0] exp_ready;
        int         win;
        bit         ok;

        vecs[0]  = mk(2'b01, 2'b00, ADD, 5, 7, ADD, 0, 0, 2'b01, 2'b00, 0, 0);
        vecs[1]  = mk(2'b10, 2'b01, ADD, 5, 7, SUB, 9, 9, 2'b10, 2'b01, 12, 0);
        vecs[2]  = mk(2'b11, 2'b00, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b00, 2'b10, 0, 1);
        vecs[3]  = mk(2'b11, 2'b01, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b00, 2'b10, 0, 1);
        vecs[4]  = mk(2'b11, 2'b00, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b00, 2'b10, 0, 1);
        vecs[5]  = mk(2'b11, 2'b10, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b01, 2'b10, 0, 1);
        vecs[6]  = mk(2'b11, 2'b11, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b10, 2'b01, 'hFF, 0);
        vecs[7]  = mk(2'b11, 2'b11, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b01, 2'b10, 7, 0);
        vecs[8]  = mk(2'b11, 2'b11, XOR, 'hF0, 'h0F, OR, 3, 4, 2'b10, 2'b01, 'hFF, 0);
        vecs[9]  = mk(2'b00, 2'b11, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b10, 7, 0);
        vecs[10] = mk(2'b01, 2'b00, ADD, 1, 2, ADD, 0, 0, 2'b01, 2'b00, 7, 0);
        vecs[11] = mk(2'b10, 2'b01, ADD, 1, 2, SUB, 10, 4, 2'b10, 2'b01, 3, 0);
        vecs[12] = mk(2'b00, 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b00, 2'b10, 6, 0);

        for (int i = 0; i < 2; i++) begin
            op_c[i] = ADD; op_a[i] = '0; op_b[i] = '0;
        end
        drive(2'b00, 2'b00);
        rst_n = 1'b0;
        #12;
        check("reset rsp_valid", bus.rsp_valid, 2'b00);
        check("reset rsp_result", bus.rsp_result, 0);
        check("reset rsp_zero", bus.rsp_zero, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: each row's expectations describe the cycle before its edge.
        for (int i = 0; i < 13; i++) begin
            op_c[0] = vecs[i].c0; op_a[0] = vecs[i].a0; op_b[0] = vecs[i].b0;
            op_c[1] = vecs[i].c1; op_a[1] = vecs[i].a1; op_b[1] = vecs[i].b1;
            drive(vecs[i].rv, vecs[i].rr);
            #3;
            check($sformatf("vec%0d req_ready", i), bus.req_ready, vecs[i].ready);
            check($sformatf("vec%0d rsp_valid", i), bus.rsp_valid, vecs[i].valid);
            check($sformatf("vec%0d rsp_result", i), bus.rsp_result, vecs[i].result);
            check($sformatf("vec%0d rsp_zero", i), bus.rsp_zero, vecs[i].zero);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while port 1 holds a result.
        check("pre-reset hold", bus.rsp_valid, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async rst rsp_valid", bus.rsp_valid, 2'b00);
        check("async rst rsp_result", bus.rsp_result, 0);
        check("async rst rsp_zero", bus.rsp_zero, 0);
        #2 rst_n = 1'b1;
        op_c[0] = SUB; op_a[0] = 20; op_b[0] = 8;
        op_c[1] = ADD; op_a[1] = 1;  op_b[1] = 1;
        drive(2'b11, 2'b00);
        #1;
        check("first tie after reset", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00);
        #1;
        check("post-reset rsp_valid", bus.rsp_valid, 2'b01);
        check("post-reset rsp_result", bus.rsp_result, 12);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        pend = 2'b00;
        rv   = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    rv[p]   = ($urandom_range(0, 2) != 0);
                    op_c[p] = 3'($urandom_range(0, 7));
                    op_a[p] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                    op_b[p] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                end
            end
            rr[0] = ($urandom_range(0, 9) < 7);
            rr[1] = ($urandom_range(0, 9) < 7);
            drive(rv, rr);
            #3;

            win = -1;
            if (rv == 2'b01)      win = 0;
            else if (rv == 2'b10) win = 1;
            else if (rv == 2'b11) win = (m_last == 1) ? 0 : 1;
            ok = !m_held || rr[m_own];
            exp_ready = (ok && win >= 0) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;

            check("rnd req_ready", bus.req_ready, exp_ready);
            check("rnd rsp_valid", bus.rsp_valid,
                  m_held ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00);
            check("rnd rsp_result", bus.rsp_result, m_res);
            check("rnd rsp_zero", bus.rsp_zero, m_zero);
            check("rnd alu_srca", bus.alu_srca, (exp_ready != 0) ? op_a[win] : '0);
            check("rnd alu_srcb", bus.alu_srcb, (exp_ready != 0) ? op_b[win] : '0);
            check("rnd alu_ctrl", bus.alu_ctrl, (exp_ready != 0) ? op_c[win] : 3'b000);

            if (exp_ready != 0) begin
                m_held = 1;
                m_own  = win;
                m_last = win;
                m_res  = alu_fn(op_c[win], op_a[win], op_b[win]);
                m_zero = (m_res == '0);
            end else if (m_held && rr[m_own]) begin
                m_held = 0;
            end
            pend = rv & ~exp_ready;
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

- Shares the single combinational `alu` between two requesters:
  - port 0 is the execute stage;
  - port 1 is the address/branch-target unit.
- Round-robin arbitration, one operation in flight.
- Registers the ALU result and zero flag, holds them until the owning requester accepts them.
- Sits between the pipeline stages and the `alu` instance; drives the ALU operands and opcode, samples its outputs.

## Interface

Parameters:
- `WIDTH`, 32: operand/result width (matches ALU).
- `CTRL_W`, 3: opcode width (matches ALU `control`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low (fixed).
- `req_valid[1:0]`  in  2  per-requester operation request.
- `req_ready[1:0]`  out  2  per-requester accept; a transfer happens when `req_valid[i] & req_ready[i]`.
- `req_srca0`, `req_srcb0`  in  WIDTH  port-0 operands.
- `req_ctrl0`  in  CTRL_W  port-0 opcode.
- `req_srca1`, `req_srcb1`  in  WIDTH  port-1 operands.
- `req_ctrl1`  in  CTRL_W  port-1 opcode.
- `rsp_valid[1:0]`  out  2  one-hot result valid for the requester that issued the op.
- `rsp_ready[1:0]`  in  2  per-requester result accept.
- `rsp_result`  out  WIDTH  registered ALU result.
- `rsp_zero`  out  1  registered ALU zero flag (only meaningful for SUB, 3'b111).
- `alu_srca`, `alu_srcb`  out  WIDTH  to the ALU.
- `alu_ctrl`  out  CTRL_W  to the ALU.
- `alu_result`  in  WIDTH  from the ALU.
- `alu_zero`  in  1  from the ALU.

## Operation

- Two states: IDLE (no result held) and HOLD (result held for owner `own`).
- Grant, combinational:
  - Only one valid requester: that requester wins.
  - Both valid: the winner is the requester not equal to `last`. `last` resets to 1, so port 0 wins the first tie.
- `req_ready[g] = 1` only for the granted requester `g`, and only when `accept_ok` holds.
  - `accept_ok = (state==IDLE) | (state==HOLD & rsp_ready[own])`.
  - This allows back-to-back issue in the cycle a held result is consumed.
- ALU drive:
  - `alu_srca/srcb/ctrl` equal the granted requester's operands when `accept_ok`.
  - Otherwise they are all zero (ctrl = ADD). This keeps the ALU inputs quiet.
- On accept:
  - `rsp_result <= alu_result`, `rsp_zero <= alu_zero`.
  - `own <= g`, `last <= g`, state -> HOLD.
- In HOLD:
  - `rsp_valid[own] = 1` and the other bit is 0.
  - Result and zero are stable until `rsp_ready[own]`.
  - `rsp_ready` on the non-owner port is ignored.
- In HOLD with `rsp_ready[own]` and no new accept: state -> IDLE. `rsp_result` and `rsp_zero` keep their last values.
- Opcodes pass through unmodified; the arbiter does not decode them.
- Requesters must hold `req_*` stable while `req_valid` is high and not accepted. This is not checked.

## Timing

- Reset values: state=IDLE, `own`=0, `last`=1, `rsp_valid`=2'b00, `rsp_result`=0, `rsp_zero`=0. `req_ready` is combinational and reflects IDLE.
- Latency: accept at edge N; `rsp_valid` high after edge N, i.e. one cycle.
- Throughput: one op per cycle when the owner asserts `rsp_ready` continuously.
- Combinational paths:
  - `req_valid`/`rsp_ready` -> `req_ready`;
  - `req_*` -> `alu_*`.
- `alu_result` -> registers is a single-cycle path.
- `rsp_*` outputs are pure registers.
- Reset mid-HOLD: the result is discarded, outputs return to reset values asynchronously, and the owner sees `rsp_valid` drop.
- Simultaneous consume and issue from the other port: the old result is consumed, the new one is registered at the same edge, and `rsp_valid` switches owner cleanly with no bubble.

## Structure

- Shared package `cpu_pkg`:
  - opcode constants ADD=3'b000, OR=3'b001, AND=3'b010, XOR=3'b011, NOR=3'b100, SLL=3'b101, ROT=3'b110, SUB=3'b111, reused by the ALU and decoder;
  - arbiter state encoding IDLE=1'b0, HOLD=1'b1.
- One sub-module: `rr_arb2`, a 2-way round-robin grant from `req` and `last`. It is combinational and reusable for memory-port sharing.

## Test plan

- After reset: port 0 requests ADD 5+7.
  - `req_ready[0]`=1 same cycle.
  - Next cycle: `rsp_valid`=2'b01, `rsp_result`=12, `rsp_zero`=0.
- Port 1 issues SUB 9-9 and holds `rsp_ready[1]`=0 for 3 cycles.
  - `rsp_valid`=2'b10, result 0 and zero 1, all stable for 3 cycles.
  - `req_ready` stays 0 for both ports throughout.
- Both ports valid for 4 consecutive cycles, both always ready, port 0 opcodes XOR and port 1 opcodes OR.
  - Grants alternate 0,1,0,1.
  - `rsp_valid` alternates 01,10,01,10 with no idle cycle.
- Port 0 holds a result while port 1 is valid, and port 0 asserts `rsp_ready[0]`.
  - Port 1 is accepted the same cycle.
  - The next cycle shows `rsp_valid`=2'b10 with port 1's result.
- Assert `rst_n`=0 asynchronously mid-HOLD (between edges).
  - `rsp_valid`=0, `rsp_result`=0 immediately.
  - After release, the first tie is granted to port 0.
- `rsp_ready[1]`=1 while port 0 owns the result.
  - No effect: the result stays held until `rsp_ready[0]`.
